// File: rtl/layer_sequencer_pkg.sv
// Shared widths and bus payload types for the layer sequencer and its neuron layer.
package layer_sequencer_pkg;

   localparam int unsigned DATA_W = 8;
   localparam int unsigned IN_N   = 5;
   localparam int unsigned OUT_N  = 4;
   localparam int unsigned CNTR_W = 5;

   typedef logic [DATA_W-1:0]            data_t;
   typedef logic [CNTR_W-1:0]            cntr_t;
   typedef logic [IN_N-1:0][DATA_W-1:0]  in_vec_t;
   typedef logic [OUT_N-1:0][DATA_W-1:0] out_vec_t;

   // All-ones counter is out of weight range, so neurons add zero and hold
   localparam cntr_t CNTR_IDLE = '1;
   localparam cntr_t K_LAST    = CNTR_W'(IN_N - 1);

endpackage

// File: rtl/layer_sequencer_if.sv
// Upstream, neuron broadcast and downstream signals of one layer sequencer.
interface layer_sequencer_if;
   import layer_sequencer_pkg::*;

   logic                      in_valid;
   logic                      in_ready;
   logic [DATA_W*IN_N-1:0]    in_vec;
   logic [CNTR_W-1:0]         cntr;
   logic                      en;
   logic [DATA_W-1:0]         d_in;
   logic [DATA_W*OUT_N-1:0]   n_out_bus;
   logic                      out_valid;
   logic                      out_ready;
   logic [DATA_W*OUT_N-1:0]   out_vec;
   logic                      busy;

   modport master (
      input  in_valid, in_vec, n_out_bus, out_ready,
      output in_ready, cntr, en, d_in, out_valid, out_vec, busy
   );

   modport slave (
      output in_valid, in_vec, n_out_bus, out_ready,
      input  in_ready, cntr, en, d_in, out_valid, out_vec, busy
   );
endinterface

// File: rtl/layer_sequencer_elem_mux.sv
// Selects element i_sel of a latched input vector; out-of-range selects give zero.
module layer_sequencer_elem_mux
   import layer_sequencer_pkg::*;
(
   input  in_vec_t i_vec,
   input  cntr_t   i_sel,
   output data_t   o_elem_c
);

   always_comb begin
      o_elem_c = '0;
      for (int unsigned k = 0; k < IN_N; k++) begin
         if (i_sel == CNTR_W'(k)) o_elem_c = i_vec[k];
      end
   end

endmodule

// File: rtl/layer_sequencer.sv
// Streams one input vector to a layer of neurons, then captures their outputs
// behind a valid/ready handshake on both sides.
module layer_sequencer
   import layer_sequencer_pkg::*;
(
   input logic              clk,
   input logic              rst_n,
   layer_sequencer_if.master bus
);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_MAC  = 2'd1;
   localparam logic [1:0] ST_CAPT = 2'd2;
   localparam logic [1:0] ST_OUT  = 2'd3;

   logic [1:0] r_state;
   logic [1:0] w_state_nxt;
   cntr_t      r_k;
   in_vec_t    r_vec;
   out_vec_t   r_out_vec;
   logic       r_out_valid;
   logic       w_accept;
   logic       w_capture;
   logic       w_k_inc;
   logic       w_mac;
   data_t      w_elem;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= ST_IDLE;
      else        r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      w_accept    = 1'b0;
      w_capture   = 1'b0;
      w_k_inc     = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (bus.in_valid) begin
               w_accept    = 1'b1;
               w_state_nxt = ST_MAC;
            end
         end
         ST_MAC: begin
            if (r_k == K_LAST) w_state_nxt = ST_CAPT;
            else               w_k_inc     = 1'b1;
         end
         ST_CAPT: begin
            w_capture   = 1'b1;
            w_state_nxt = ST_OUT;
         end
         ST_OUT: begin
            // Retiring and accepting on the same edge keeps back-to-back throughput
            if (bus.out_ready) begin
               if (bus.in_valid) begin
                  w_accept    = 1'b1;
                  w_state_nxt = ST_MAC;
               end else begin
                  w_state_nxt = ST_IDLE;
               end
            end
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_k         <= '0;
         r_vec       <= '0;
         r_out_vec   <= '0;
         r_out_valid <= 1'b0;
      end else begin
         if (w_accept) begin
            r_vec <= bus.in_vec;
            r_k   <= '0;
         end else if (w_k_inc) begin
            r_k <= r_k + CNTR_W'(1);
         end
         if (w_capture) r_out_vec <= bus.n_out_bus;
         r_out_valid <= (w_state_nxt == ST_OUT);
      end
   end

   layer_sequencer_elem_mux u_elem_mux (
      .i_vec    (r_vec),
      .i_sel    (r_k),
      .o_elem_c (w_elem)
   );

   assign w_mac         = (r_state == ST_MAC);
   assign bus.cntr      = w_mac ? r_k : CNTR_IDLE;
   assign bus.en        = w_mac && (r_k == '0);
   assign bus.d_in      = w_mac ? w_elem : '0;
   assign bus.out_valid = r_out_valid;
   assign bus.out_vec   = r_out_vec;
   assign bus.busy      = w_mac || (r_state == ST_CAPT);
   // Gated by rst_n so nothing is offered upstream while reset is asserted
   assign bus.in_ready  = rst_n && ((r_state == ST_IDLE) ||
                                    ((r_state == ST_OUT) && bus.out_ready));

endmodule
